// File: rtl/fwd_pkg.sv
// Shared definitions for the ID/EX forwarding controller: operand-mux select
// codes and register-tag helpers.
package fwd_pkg;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_ZERO = 2'b11
   } fwd_sel_e;

   // Widest tag the helpers accept; callers zero-extend narrower tags.
   localparam int TAG_MAX_W = 8;
   typedef logic [TAG_MAX_W-1:0] tag_t;

   // Integer x0 is all zeros; FP f0 has the is_fp MSB set and stays a real register.
   function automatic logic is_x0(input tag_t tag);
      return tag == '0;
   endfunction

   function automatic logic tag_hit(input tag_t src, input tag_t dst, input logic we);
      return we && (src == dst) && !is_x0(src);
   endfunction

endpackage

// File: rtl/fpa_scoreboard.sv
// In-flight FPA destination tracker: one {v, rd} slot per FPA pipeline stage,
// flagging sources whose result cannot be forwarded by the next cycle.
module fpa_scoreboard
   import fwd_pkg::*;
#(
   parameter int RA_W    = 6,
   parameter int FPA_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            accept,
   input  logic [RA_W-1:0] rd,
   input  logic [RA_W-1:0] rs1,
   input  logic            rs1_use,
   input  logic [RA_W-1:0] rs2,
   input  logic            rs2_use,
   output logic            hazard_a,
   output logic            hazard_b
);

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] rd;
   } slot_t;

   slot_t slots [FPA_LAT];

   // NOTE: every slot is reset, not just v, so a mid-stream reset forgets all in-flight tags at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FPA_LAT; i++) slots[i] <= '0;
      end else begin
         slots[0] <= '{v: accept, rd: rd};
         for (int i = 1; i < FPA_LAT; i++) slots[i] <= slots[i-1];
      end
   end

   // Only slots up to FPA_LAT-3 stall; slot FPA_LAT-2 is already visible as ex_rd.
   always_comb begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      for (int i = 0; i < FPA_LAT - 2; i++) begin
         if (rs1_use && tag_hit(tag_t'(rs1), tag_t'(slots[i].rd), slots[i].v)) hazard_a = 1'b1;
         if (rs2_use && tag_hit(tag_t'(rs2), tag_t'(slots[i].rd), slots[i].v)) hazard_b = 1'b1;
      end
   end

   logic unused_tail;
   assign unused_tail = &{1'b0, slots[FPA_LAT-1]};

endmodule

// File: rtl/fwd_ctrl.sv
// ID/EX forwarding and hazard controller. Define FWD_FPA_SB_EN to include the
// multi-cycle FPA scoreboard; otherwise only load-use stalls are generated.
module fwd_ctrl
   import fwd_pkg::*;
#(
   parameter int RA_W    = 6,
   parameter int FPA_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_rs1_use,
   input  logic            id_rs2_use,
   input  logic            id_fpa_issue,
   input  logic [RA_W-1:0] id_rd,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_we,
   input  logic            ex_is_load,
   input  logic [RA_W-1:0] exm_rd,
   input  logic            exm_we,
   input  logic            flush,
   output logic [1:0]      fwd_a_sel,
   output logic [1:0]      fwd_b_sel,
   output logic            stall
);

   logic     a_ex, a_exm, b_ex, b_exm;
   logic     load_use, sb_a, sb_b;
   fwd_sel_e sel_a, sel_b;

   assign a_ex  = id_rs1_use && tag_hit(tag_t'(id_rs1), tag_t'(ex_rd),  ex_we);
   assign a_exm = id_rs1_use && tag_hit(tag_t'(id_rs1), tag_t'(exm_rd), exm_we);
   assign b_ex  = id_rs2_use && tag_hit(tag_t'(id_rs2), tag_t'(ex_rd),  ex_we);
   assign b_exm = id_rs2_use && tag_hit(tag_t'(id_rs2), tag_t'(exm_rd), exm_we);

   // NOTE: each select gets a default before the priority chain so no latch is inferred.
   always_comb begin
      sel_a = FWD_RF;
      if (a_ex)       sel_a = FWD_MEM;
      else if (a_exm) sel_a = FWD_WB;
      sel_b = FWD_RF;
      if (b_ex)       sel_b = FWD_MEM;
      else if (b_exm) sel_b = FWD_WB;
   end

   assign load_use = ex_is_load && (a_ex || b_ex);
   assign stall    = id_valid && (load_use || sb_a || sb_b);

`ifdef FWD_FPA_SB_EN
   logic accept;
   assign accept = id_valid && id_fpa_issue && !stall && !flush;

   fpa_scoreboard #(
      .RA_W    (RA_W),
      .FPA_LAT (FPA_LAT)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .accept   (accept),
      .rd       (id_rd),
      .rs1      (id_rs1),
      .rs1_use  (id_rs1_use),
      .rs2      (id_rs2),
      .rs2_use  (id_rs2_use),
      .hazard_a (sb_a),
      .hazard_b (sb_b)
   );
`else
   assign sb_a = 1'b0;
   assign sb_b = 1'b0;

   logic unused_fpa;
   assign unused_fpa = &{1'b0, id_fpa_issue, id_rd, FPA_LAT[0]};
`endif

   // NOTE: sequential state uses non-blocking assignments; a stall or flush loads a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else if (stall || flush) begin
         fwd_a_sel <= FWD_RF;
         fwd_b_sel <= FWD_RF;
      end else begin
         fwd_a_sel <= sel_a;
         fwd_b_sel <= sel_b;
      end
   end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: directed hazard scenarios plus randomized
// traffic against an age-based reference model of forwarding and stalls.
module tb_fwd_ctrl;

   localparam int RA_W = 6;
   localparam int LAT  = 3;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            id_valid = 1'b0;
   logic [RA_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic            id_rs1_use = 1'b0, id_rs2_use = 1'b0, id_fpa_issue = 1'b0;
   logic [RA_W-1:0] ex_rd = '0, exm_rd = '0;
   logic            ex_we = 1'b0, ex_is_load = 1'b0, exm_we = 1'b0, flush = 1'b0;
   logic [1:0]      fwd_a_sel, fwd_b_sel;
   logic            stall;

   fwd_ctrl #(.RA_W(RA_W), .FPA_LAT(LAT)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_rs1_use   (id_rs1_use),
      .id_rs2_use   (id_rs2_use),
      .id_fpa_issue (id_fpa_issue),
      .id_rd        (id_rd),
      .ex_rd        (ex_rd),
      .ex_we        (ex_we),
      .ex_is_load   (ex_is_load),
      .exm_rd       (exm_rd),
      .exm_we       (exm_we),
      .flush        (flush),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: accepted FPA ops remembered with the cycle they were accepted.
   typedef struct {
      logic [RA_W-1:0] rd;
      int              t;
   } issue_t;

   issue_t q[$];
   int     cyc = 0;

   function automatic logic hit(input logic [RA_W-1:0] s, input logic [RA_W-1:0] w, input logic we);
      return we && (s == w) && (s != '0);
   endfunction

   // A result accepted `age` cycles ago is unforwardable while age <= LAT-2.
   function automatic logic sb_dep(input logic [RA_W-1:0] s, input logic use_src);
      logic r;
      r = 1'b0;
`ifdef FWD_FPA_SB_EN
      foreach (q[k]) begin
         if (use_src && hit(s, q[k].rd, 1'b1) && (cyc - q[k].t >= 1) && (cyc - q[k].t <= LAT - 2))
            r = 1'b1;
      end
`endif
      return r;
   endfunction

   function automatic logic [1:0] exp_sel(input logic use_src, input logic ex_h, input logic exm_h);
      if (!use_src) return 2'b00;
      if (ex_h)     return 2'b10;
      if (exm_h)    return 2'b01;
      return 2'b00;
   endfunction

   task automatic drive(input logic v, input logic [RA_W-1:0] r1, input logic u1,
                        input logic [RA_W-1:0] r2, input logic u2,
                        input logic fi, input logic [RA_W-1:0] rd,
                        input logic [RA_W-1:0] exr, input logic exw, input logic exl,
                        input logic [RA_W-1:0] mr, input logic mw, input logic fl);
      id_valid = v;  id_rs1 = r1; id_rs1_use = u1; id_rs2 = r2; id_rs2_use = u2;
      id_fpa_issue = fi; id_rd = rd;
      ex_rd = exr; ex_we = exw; ex_is_load = exl;
      exm_rd = mr; exm_we = mw; flush = fl;
   endtask

   // One ID cycle: check stall before the edge, selects after it.
   task automatic step(output logic st);
      logic       a_ex, b_ex, a_m, b_m, es, acc;
      logic [1:0] ea, eb;
      #1;
      a_ex = hit(id_rs1, ex_rd, ex_we);
      b_ex = hit(id_rs2, ex_rd, ex_we);
      a_m  = hit(id_rs1, exm_rd, exm_we);
      b_m  = hit(id_rs2, exm_rd, exm_we);
      es = id_valid && ((ex_is_load && ((id_rs1_use && a_ex) || (id_rs2_use && b_ex)))
                        || sb_dep(id_rs1, id_rs1_use) || sb_dep(id_rs2, id_rs2_use));
      check("stall", {7'b0, stall}, {7'b0, es});
      st = stall;
      ea = (es || flush) ? 2'b00 : exp_sel(id_rs1_use, a_ex, a_m);
      eb = (es || flush) ? 2'b00 : exp_sel(id_rs2_use, b_ex, b_m);
      acc = id_valid && id_fpa_issue && !es && !flush;
      @(posedge clk);
      cyc++;
      if (acc) q.push_back('{rd: id_rd, t: cyc - 1});
      while (q.size() > 0 && (cyc - q[0].t > LAT)) void'(q.pop_front());
      #1;
      check("fwd_a_sel", {6'b0, fwd_a_sel}, {6'b0, ea});
      check("fwd_b_sel", {6'b0, fwd_b_sel}, {6'b0, eb});
   endtask

   logic [RA_W-1:0] pool [6] = '{6'h00, 6'h05, 6'h07, 6'h0A, 6'h20, 6'h23};

   function automatic logic [RA_W-1:0] rtag();
      if ($urandom_range(0, 7) == 0) return RA_W'($urandom);
      return pool[$urandom_range(0, 5)];
   endfunction

   initial begin
      logic st;
      int   nst;
      int   exp_nst;

      #1;
      check("rst_a_sel", {6'b0, fwd_a_sel}, 8'h00);
      check("rst_b_sel", {6'b0, fwd_b_sel}, 8'h00);
      check("rst_stall", {7'b0, stall}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // EX forward
      drive(1, 6'h05, 1, 6'h01, 1, 0, 6'h00, 6'h05, 1, 0, 6'h00, 0, 0);
      step(st);
      check("ex_fwd_sel", {6'b0, fwd_a_sel}, 8'h02);
      check("ex_fwd_stall", {7'b0, st}, 8'h00);

      // EX beats EX/MEM, and x0 never forwards
      drive(1, 6'h07, 1, 6'h07, 1, 0, 6'h00, 6'h07, 1, 0, 6'h07, 1, 0);
      step(st);
      check("prio_sel", {6'b0, fwd_a_sel}, 8'h02);
      drive(1, 6'h01, 1, 6'h00, 1, 0, 6'h00, 6'h00, 1, 0, 6'h00, 1, 0);
      step(st);
      check("x0_sel", {6'b0, fwd_b_sel}, 8'h00);

      // Load-use: one stall with bubble, then WB forward
      drive(1, 6'h01, 1, 6'h0A, 1, 0, 6'h00, 6'h0A, 1, 1, 6'h00, 0, 0);
      step(st);
      check("lu_stall", {7'b0, st}, 8'h01);
      check("lu_bubble", {6'b0, fwd_b_sel}, 8'h00);
      drive(1, 6'h01, 1, 6'h0A, 1, 0, 6'h00, 6'h00, 0, 0, 6'h0A, 1, 0);
      step(st);
      check("lu_after_stall", {7'b0, st}, 8'h00);
      check("lu_wb_sel", {6'b0, fwd_b_sel}, 8'h01);

      // FPA dependency: count stall cycles before the dependent proceeds
`ifdef FWD_FPA_SB_EN
      exp_nst = 1;
`else
      exp_nst = 0;
`endif
      drive(1, 6'h01, 1, 6'h02, 1, 1, 6'h23, 6'h00, 0, 0, 6'h00, 0, 0);
      step(st);
      nst = 0;
      drive(1, 6'h23, 1, 6'h02, 1, 0, 6'h00, 6'h23, 1, 0, 6'h00, 0, 0);
      step(st);
      while (st && nst < 6) begin
         nst++;
         step(st);
      end
      check("fpa_stall_cycles", 8'(nst), 8'(exp_nst));
      check("fpa_fwd_sel", {6'b0, fwd_a_sel}, 8'h02);

      // Flush on the stalling cycle does not drop the stall
      drive(1, 6'h01, 1, 6'h02, 1, 1, 6'h23, 6'h00, 0, 0, 6'h00, 0, 0);
      step(st);
      drive(1, 6'h03, 1, 6'h23, 1, 0, 6'h00, 6'h00, 0, 0, 6'h00, 0, 1);
      step(st);
      check("flush_stall", {7'b0, st}, 8'(exp_nst));
      check("flush_bubble", {6'b0, fwd_b_sel}, 8'h00);

      // Reset in the middle of a scoreboard stall
      drive(1, 6'h01, 1, 6'h02, 1, 1, 6'h23, 6'h00, 0, 0, 6'h00, 0, 0);
      step(st);
      drive(1, 6'h23, 1, 6'h02, 1, 0, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0);
      #2;
      check("mid_stall", {7'b0, stall}, 8'(exp_nst));
      rst_n = 1'b0;
      #1;
      check("mid_rst_a_sel", {6'b0, fwd_a_sel}, 8'h00);
      check("mid_rst_b_sel", {6'b0, fwd_b_sel}, 8'h00);
      id_valid = 1'b0;
      #1;
      check("mid_rst_stall", {7'b0, stall}, 8'h00);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 6'h23, 1, 6'h02, 1, 0, 6'h00, 6'h00, 0, 0, 6'h00, 0, 0);
      step(st);
      check("post_rst_stall", {7'b0, st}, 8'h00);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 7) != 0, rtag(), $urandom_range(0, 3) != 0,
               rtag(), $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, rtag(),
               rtag(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
               rtag(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
         step(st);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
